// File: rtl/lsu_mem_master.sv
`default_nettype none
// ============================================================================
// Module  : lsu_mem_master
// Purpose : RV32I load/store unit, initiator side of the data RAM port.
//           Define LSU_TIMEOUT_EN to bound the wait for read data.
// Rev     : 1.0
// ============================================================================
module lsu_mem_master #(
  parameter int ADDR_W  = 10,
  parameter int WR_WAIT = 2,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr_in,
  input  logic [31:0]       st_data,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [31:0]       ld_data,
  output logic              mem_read,
  output logic              mem_write,
  output logic [3:0]        mem_byteena,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_valid,
  input  logic [31:0]       mem_rdata
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT_RD = 3'd2;
  localparam logic [2:0] S_WAIT_WR = 3'd3;
  localparam logic [2:0] S_FIN     = 3'd4;

  localparam int                WCNT_W    = $clog2(WR_WAIT + 1);
  localparam logic [WCNT_W-1:0] WCNT_INIT = WCNT_W'(WR_WAIT - 1);
  localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);

  logic [2:0]        state_q, state_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic              st_q, st_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              fault_q, fault_d;
  logic [31:0]       ld_data_q, ld_data_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [3:0]        mem_byteena_q, mem_byteena_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  logic              accept;
  logic              legal;
  logic              timeout_hit;
  logic [3:0]        be_calc;
  logic [31:0]       wdata_calc;
  logic [31:0]       rd_shift;
  logic [31:0]       ld_fmt;
  logic              unused_addr_hi;

  assign unused_addr_hi = ^addr_in[31:ADDR_W+2];

  // FIN is the last cycle of an access, so a request there is taken exactly
  // as it would be in IDLE; the RAM controller is already idle by then.
  assign accept = req && ((state_q == S_IDLE) || (state_q == S_FIN));

`ifdef LSU_TIMEOUT_EN
  localparam int                TCNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [TCNT_W-1:0] TCNT_INIT = TCNT_W'(TIMEOUT - 1);
  localparam logic [TCNT_W-1:0] TCNT_ONE  = TCNT_W'(1);

  logic [TCNT_W-1:0] tcnt_q, tcnt_d;

  assign timeout_hit = (state_q == S_WAIT_RD) && !mem_valid && (tcnt_q == '0);
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    legal = 1'b0;
    case (funct3[1:0])
      2'b00:   legal = 1'b1;
      2'b01:   legal = ~addr_in[0];
      2'b10:   legal = (addr_in[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
    // Loads only allow the unsigned byte/half variants with funct3[2] set.
    if (funct3[2] && (is_store || funct3[1])) begin
      legal = 1'b0;
    end
  end

  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = st_data;
    case (funct3[1:0])
      2'b00: begin
        be_calc    = 4'b0001 << addr_in[1:0];
        wdata_calc = {4{st_data[7:0]}};
      end
      2'b01: begin
        be_calc    = addr_in[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{st_data[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = st_data;
      end
    endcase
  end

  always_comb begin
    rd_shift = mem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ld_fmt = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  ld_fmt = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  ld_fmt = {24'd0, rd_shift[7:0]};
      3'b101:  ld_fmt = {16'd0, rd_shift[15:0]};
      default: ld_fmt = rd_shift;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      f3_q          <= '0;
      off_q         <= '0;
      st_q          <= 1'b0;
      wcnt_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      fault_q       <= 1'b0;
      ld_data_q     <= '0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_byteena_q <= '0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
`ifdef LSU_TIMEOUT_EN
      tcnt_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      f3_q          <= f3_d;
      off_q         <= off_d;
      st_q          <= st_d;
      wcnt_q        <= wcnt_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      fault_q       <= fault_d;
      ld_data_q     <= ld_data_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_byteena_q <= mem_byteena_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
`ifdef LSU_TIMEOUT_EN
      tcnt_q        <= tcnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    f3_d    = f3_q;
    off_d   = off_q;
    st_d    = st_q;
    wcnt_d  = wcnt_q;
`ifdef LSU_TIMEOUT_EN
    tcnt_d  = tcnt_q;
`endif
    case (state_q)
      S_IDLE, S_FIN: begin
        state_d = S_IDLE;
        if (accept) begin
          f3_d    = funct3;
          off_d   = addr_in[1:0];
          st_d    = is_store;
          state_d = legal ? S_ISSUE : S_FIN;
        end
      end
      S_ISSUE: begin
        if (st_q) begin
          state_d = S_WAIT_WR;
          wcnt_d  = WCNT_INIT;
        end else begin
          state_d = S_WAIT_RD;
`ifdef LSU_TIMEOUT_EN
          tcnt_d  = TCNT_INIT;
`endif
        end
      end
      S_WAIT_RD: begin
        if (mem_valid) begin
          state_d = S_FIN;
        end else if (timeout_hit) begin
          state_d = S_FIN;
        end else begin
`ifdef LSU_TIMEOUT_EN
          tcnt_d  = tcnt_q - TCNT_ONE;
`endif
        end
      end
      S_WAIT_WR: begin
        wcnt_d = wcnt_q - WCNT_ONE;
        if (wcnt_q <= WCNT_ONE) begin
          state_d = S_FIN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_FIN);
    fault_d       = (accept && !legal) || timeout_hit;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    mem_byteena_d = mem_byteena_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    ld_data_d     = ld_data_q;
    if (accept && legal) begin
      mem_read_d    = !is_store;
      mem_write_d   = is_store;
      mem_byteena_d = be_calc;
      mem_addr_d    = addr_in[ADDR_W+1:2];
      mem_wdata_d   = wdata_calc;
    end
    if ((state_q == S_WAIT_RD) && mem_valid) begin
      ld_data_d = ld_fmt;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign fault       = fault_q;
  assign ld_data     = ld_data_q;
  assign mem_read    = mem_read_q;
  assign mem_write   = mem_write_q;
  assign mem_byteena = mem_byteena_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_lsu_mem_master
// Purpose : Directed vectors for lsu_mem_master with a scoreboard on the
//           done response and on the RAM strobes, plus a small RAM model.
// Rev     : 1.0
// ============================================================================
module tb_lsu_mem_master;

  localparam int ADDR_W  = 10;
  localparam int WR_WAIT = 2;
  localparam int TIMEOUT = 16;

  logic              clk       = 1'b0;
  logic              rst       = 1'b0;
  logic              req       = 1'b0;
  logic              is_store  = 1'b0;
  logic [2:0]        funct3    = 3'b000;
  logic [31:0]       addr_in   = 32'h0;
  logic [31:0]       st_data   = 32'h0;
  logic              mem_valid = 1'b0;
  logic [31:0]       mem_rdata = 32'h0;
  logic              busy, done, fault, mem_read, mem_write;
  logic [31:0]       ld_data, mem_wdata;
  logic [3:0]        mem_byteena;
  logic [ADDR_W-1:0] mem_addr;

  lsu_mem_master #(.ADDR_W(ADDR_W), .WR_WAIT(WR_WAIT), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .is_store(is_store), .funct3(funct3),
    .addr_in(addr_in), .st_data(st_data), .busy(busy), .done(done),
    .fault(fault), .ld_data(ld_data), .mem_read(mem_read),
    .mem_write(mem_write), .mem_byteena(mem_byteena), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_valid(mem_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic flt; logic [31:0] ld; } done_exp_t;
  typedef struct { int cyc; logic wr; logic [9:0] addr; logic [3:0] be; logic [31:0] wd; } strb_exp_t;

  done_exp_t done_q[$];
  strb_exp_t strb_q[$];
  int cyc = 0, n_vec = 0, n_miss = 0, n_done = 0, n_exp_done = 0;

  logic [31:0] ram [0:1023];
  bit          rd_pend  = 1'b0;
  bit          ram_mute = 1'b0;
  int          rd_cyc   = 0;
  logic [9:0]  rd_addr  = '0;
  logic [3:0]  rd_be    = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, required 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // RAM controller: read data arrives three cycles after the read strobe.
  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
    ram[4] = 32'h80FF1234;
    forever begin
      @(posedge clk);
      #1;
      mem_valid = 1'b0;
      if (mem_write === 1'b1)
        ram[mem_addr] = (ram[mem_addr] & ~lane_mask(mem_byteena)) | (mem_wdata & lane_mask(mem_byteena));
      if (rd_pend && cyc == rd_cyc + 3) begin
        mem_valid = !ram_mute;
        mem_rdata = ram[rd_addr] & lane_mask(rd_be);
        rd_pend   = 1'b0;
      end
      if (mem_read === 1'b1) begin
        rd_pend = 1'b1;
        rd_cyc  = cyc;
        rd_addr = mem_addr;
        rd_be   = mem_byteena;
      end
    end
  end

  initial begin
    done_exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        n_done++;
        if (done_q.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL done_unexpected: got done=1 at cycle %0d, required no done", cyc);
        end else begin
          e = done_q.pop_front();
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
          chk("fault", 32'(fault), 32'(e.flt));
          chk("ld_data", ld_data, e.ld);
        end
      end
    end
  end

  initial begin
    strb_exp_t s;
    forever begin
      @(negedge clk);
      if (mem_read === 1'b1 || mem_write === 1'b1) begin
        if (strb_q.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL strobe_unexpected: got rd=%0b wr=%0b at cycle %0d, required none", mem_read, mem_write, cyc);
        end else begin
          s = strb_q.pop_front();
          chk("strobe_cycle", 32'(cyc), 32'(s.cyc));
          chk("mem_write", 32'(mem_write), 32'(s.wr));
          chk("mem_read", 32'(mem_read), 32'(!s.wr));
          chk("mem_addr", 32'(mem_addr), 32'(s.addr));
          chk("mem_byteena", 32'(mem_byteena), 32'(s.be));
          if (s.wr) chk("mem_wdata", mem_wdata, s.wd);
        end
      end
    end
  end

  // Called at #1 after a rising edge; that cycle is cycle 0 of the access.
  task automatic launch(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input bit ef, input logic [31:0] eld,
                        input logic [9:0] eaddr, input logic [3:0] ebe,
                        input logic [31:0] ewd, input int lat, input bit want_done);
    done_exp_t d;
    strb_exp_t s;
    if (want_done) begin
      d.cyc = cyc + lat; d.flt = ef; d.ld = eld;
      done_q.push_back(d);
      n_exp_done++;
    end
    if (!ef) begin
      s.cyc = cyc + 1; s.wr = st; s.addr = eaddr; s.be = ebe; s.wd = ewd;
      strb_q.push_back(s);
    end
    is_store = st; funct3 = f3; addr_in = a; st_data = sd; req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (n_done < n_exp_done && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (n_done < n_exp_done) begin
      n_vec++; n_miss++;
      $display("FAIL done_timeout: got %0d dones, required %0d", n_done, n_exp_done);
      n_exp_done = n_done;
    end
  endtask

  task automatic idle_check();
    @(posedge clk);
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_done", 32'(done), 32'h0);
    @(posedge clk);
    #1;
  endtask

  task automatic access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input bit ef, input logic [31:0] eld,
                        input logic [9:0] eaddr, input logic [3:0] ebe,
                        input logic [31:0] ewd, input int lat);
    launch(st, f3, a, sd, ef, eld, eaddr, ebe, ewd, lat, 1'b1);
    wait_done();
    idle_check();
  endtask

  task automatic zero_check(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_fault"}, 32'(fault), 32'h0);
    chk({tag, "_ld_data"}, ld_data, 32'h0);
    chk({tag, "_mem_read"}, 32'(mem_read), 32'h0);
    chk({tag, "_mem_write"}, 32'(mem_write), 32'h0);
    chk({tag, "_mem_byteena"}, 32'(mem_byteena), 32'h0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    zero_check("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    //      st f3      addr          st_data       flt ld_data       maddr  be       wdata         lat
    access(0, 3'b000, 32'h13,       32'h0,        0, 32'hFFFFFF80, 10'd4, 4'b1000, 32'h0,        5);
    access(0, 3'b100, 32'h13,       32'h0,        0, 32'h00000080, 10'd4, 4'b1000, 32'h0,        5);
    access(0, 3'b001, 32'h12,       32'h0,        0, 32'hFFFF80FF, 10'd4, 4'b1100, 32'h0,        5);
    access(0, 3'b101, 32'h11,       32'h0,        1, 32'hFFFF80FF, 10'd0, 4'b0000, 32'h0,        1);
    access(1, 3'b010, 32'h10,       32'hDEADBEEF, 0, 32'hFFFF80FF, 10'd4, 4'b1111, 32'hDEADBEEF, 3);
    access(1, 3'b000, 32'h13,       32'h000000A5, 0, 32'hFFFF80FF, 10'd4, 4'b1000, 32'hA5A5A5A5, 3);
    access(0, 3'b010, 32'h1010,     32'h0,        0, 32'hA5ADBEEF, 10'd4, 4'b1111, 32'h0,        5);
    access(0, 3'b101, 32'h12,       32'h0,        0, 32'h0000A5AD, 10'd4, 4'b1100, 32'h0,        5);
    access(0, 3'b001, 32'h10,       32'h0,        0, 32'hFFFFBEEF, 10'd4, 4'b0011, 32'h0,        5);
    access(1, 3'b001, 32'h16,       32'h1234CAFE, 0, 32'hFFFFBEEF, 10'd5, 4'b1100, 32'hCAFECAFE, 3);
    access(0, 3'b100, 32'h17,       32'h0,        0, 32'h000000CA, 10'd5, 4'b1000, 32'h0,        5);
    access(0, 3'b011, 32'h10,       32'h0,        1, 32'h000000CA, 10'd0, 4'b0000, 32'h0,        1);
    access(1, 3'b100, 32'h10,       32'h1,        1, 32'h000000CA, 10'd0, 4'b0000, 32'h0,        1);
    access(1, 3'b010, 32'h12,       32'h1,        1, 32'h000000CA, 10'd0, 4'b0000, 32'h0,        1);
    access(0, 3'b010, 32'h11,       32'h0,        1, 32'h000000CA, 10'd0, 4'b0000, 32'h0,        1);
    access(1, 3'b011, 32'h10,       32'h1,        1, 32'h000000CA, 10'd0, 4'b0000, 32'h0,        1);
    access(0, 3'b110, 32'h10,       32'h0,        1, 32'h000000CA, 10'd0, 4'b0000, 32'h0,        1);
    access(0, 3'b000, 32'h16,       32'h0,        0, 32'hFFFFFFFE, 10'd5, 4'b0100, 32'h0,        5);

    // Store, stray requests while busy, then a load issued on the done cycle.
    launch(1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 32'hFFFFFFFE, 10'd4, 4'b1111, 32'hDEADBEEF, 3, 1'b1);
    is_store = 1'b0; funct3 = 3'b000; addr_in = 32'h20; req = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    launch(0, 3'b010, 32'h10, 32'h0, 0, 32'hDEADBEEF, 10'd4, 4'b1111, 32'h0, 5, 1'b1);
    wait_done();
    idle_check();

    // Reset while waiting for read data abandons the access.
    launch(0, 3'b010, 32'h10, 32'h0, 0, 32'h0, 10'd4, 4'b1111, 32'h0, 5, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    rd_pend = 1'b0;
    @(posedge clk);
    @(negedge clk);
    zero_check("midreset");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    access(0, 3'b000, 32'h10, 32'h0, 0, 32'hFFFFFFEF, 10'd4, 4'b0001, 32'h0, 5);

`ifdef LSU_TIMEOUT_EN
    ram_mute = 1'b1;
    access(0, 3'b010, 32'h10, 32'h0, 1, 32'hFFFFFFEF, 10'd4, 4'b1111, 32'h0, 2 + TIMEOUT);
    ram_mute = 1'b0;
    repeat (6) @(posedge clk);
    #1;
`endif

    repeat (4) @(posedge clk);
    chk("pending_done", 32'(done_q.size()), 32'h0);
    chk("pending_strobe", 32'(strb_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
